usb_txn_sequencer: RTL and testbench

Host-side transaction controller that sequences the USB packet encoder (99-bit packet word in, serial bitstream out) and monitors the packet decoder. It runs one OUT transaction (OUT token, DATA0, await handshake) or one IN transaction (IN token, await DATA, reply ACK) per request. It retries on NAK, bad CRC or timeout, up to a retry limit, and reports pass/fail to the host interface.

---
 rtl/usb_txn_sequencer.sv | 247 ++++++++++++++++++++++++
 tb/tb_usb_txn_sequencer.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_txn_sequencer.sv
// Host-side USB transaction sequencer. It feeds token/data/handshake packet words to the encoder
// and watches the decoder for replies, retrying on NAK, bad CRC or timeout.
module usb_txn_sequencer #(
    parameter int TIMEOUT   = 255,
    parameter int MAX_RETRY = 8
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        start,
    input  logic        is_in,
    input  logic [6:0]  addr,
    input  logic [3:0]  endp,
    input  logic [63:0] wr_data,
    output logic        busy,
    output logic        done,
    output logic        success,
    output logic [63:0] rd_data,
    output logic [98:0] enc_pkt,
    output logic        enc_avail,
    input  logic        enc_ready,
    input  logic        rx_valid,
    input  logic [3:0]  rx_pid,
    input  logic        rx_crc_ok,
    input  logic [63:0] rx_data
);
    localparam int RW = $clog2(MAX_RETRY + 1);
    localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY - 1);
    localparam logic [7:0]    TMO_LAST   = 8'(TIMEOUT);

    localparam logic [3:0] PID_OUT   = 4'b1000;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_DATA0 = 4'b1100;
    localparam logic [3:0] PID_DATA1 = 4'b1101;
    localparam logic [3:0] PID_ACK   = 4'b0100;

    typedef enum logic [3:0] {
        S_IDLE,
        S_SEND_TOK,
        S_TX_TOK,
        S_SEND_DATA,
        S_TX_DATA,
        S_WAIT_HS,
        S_WAIT_RX,
        S_SEND_ACK,
        S_TX_ACK,
        S_FINISH
    } state_t;

    state_t          state_q, state_d;
    logic            is_in_q, is_in_d;
    logic [6:0]      addr_q, addr_d;
    logic [3:0]      endp_q, endp_d;
    logic [63:0]     wr_data_q, wr_data_d;
    logic [RW-1:0]   retry_q, retry_d;
    logic [7:0]      tmo_q, tmo_d;
    logic            tx_low_q, tx_low_d;
    logic            success_q, success_d;
    logic [63:0]     rd_data_q, rd_data_d;
    logic [98:0]     enc_pkt_q, enc_pkt_d;
    logic            retry_evt;
    logic            tx_done;

    function automatic logic [98:0] pkt_hdr(input logic [3:0] pid);
        logic [98:0] p;
        p         = '0;
        p[98:91]  = 8'b0000_0001;
        p[90:87]  = pid;
        p[86:83]  = ~pid;
        return p;
    endfunction

    // Address and endpoint go out LSB first, so they land bit-reversed in the word.
    function automatic logic [98:0] tok_pkt(input logic [3:0] pid, input logic [6:0] a,
                                            input logic [3:0] e);
        logic [98:0] p;
        p        = pkt_hdr(pid);
        p[82:76] = {<<{a}};
        p[75:72] = {<<{e}};
        return p;
    endfunction

    function automatic logic [98:0] data_pkt(input logic [63:0] d);
        logic [98:0] p;
        p        = pkt_hdr(PID_DATA0);
        p[82:19] = {<<{d}};
        return p;
    endfunction

    // Transmission is complete once enc_ready has dropped and then come back.
    assign tx_done = tx_low_q & enc_ready;

    always_comb begin
        state_d   = state_q;
        is_in_d   = is_in_q;
        addr_d    = addr_q;
        endp_d    = endp_q;
        wr_data_d = wr_data_q;
        retry_d   = retry_q;
        tmo_d     = tmo_q;
        tx_low_d  = tx_low_q;
        success_d = success_q;
        rd_data_d = rd_data_q;
        enc_pkt_d = enc_pkt_q;
        retry_evt = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    is_in_d   = is_in;
                    addr_d    = addr;
                    endp_d    = endp;
                    wr_data_d = wr_data;
                    retry_d   = '0;
                    success_d = 1'b0;
                    enc_pkt_d = tok_pkt(is_in ? PID_IN : PID_OUT, addr, endp);
                    state_d   = S_SEND_TOK;
                end
            end
            S_SEND_TOK: begin
                if (enc_ready) begin
                    tx_low_d = 1'b0;
                    state_d  = S_TX_TOK;
                end
            end
            S_TX_TOK: begin
                tx_low_d = tx_low_q | ~enc_ready;
                if (tx_done) begin
                    if (is_in_q) begin
                        tmo_d   = '0;
                        state_d = S_WAIT_RX;
                    end else begin
                        enc_pkt_d = data_pkt(wr_data_q);
                        state_d   = S_SEND_DATA;
                    end
                end
            end
            S_SEND_DATA: begin
                if (enc_ready) begin
                    tx_low_d = 1'b0;
                    state_d  = S_TX_DATA;
                end
            end
            S_TX_DATA: begin
                tx_low_d = tx_low_q | ~enc_ready;
                if (tx_done) begin
                    tmo_d   = '0;
                    state_d = S_WAIT_HS;
                end
            end
            S_WAIT_HS: begin
                tmo_d = tmo_q + 8'd1;
                if (rx_valid) begin
                    if (rx_pid == PID_ACK && rx_crc_ok) begin
                        success_d = 1'b1;
                        state_d   = S_FINISH;
                    end else begin
                        retry_evt = 1'b1;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    retry_evt = 1'b1;
                end
            end
            S_WAIT_RX: begin
                tmo_d = tmo_q + 8'd1;
                if (rx_valid) begin
                    if ((rx_pid == PID_DATA0 || rx_pid == PID_DATA1) && rx_crc_ok) begin
                        rd_data_d = rx_data;
                        enc_pkt_d = pkt_hdr(PID_ACK);
                        state_d   = S_SEND_ACK;
                    end else begin
                        retry_evt = 1'b1;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    retry_evt = 1'b1;
                end
            end
            S_SEND_ACK: begin
                if (enc_ready) begin
                    tx_low_d = 1'b0;
                    state_d  = S_TX_ACK;
                end
            end
            S_TX_ACK: begin
                tx_low_d = tx_low_q | ~enc_ready;
                if (tx_done) begin
                    success_d = 1'b1;
                    state_d   = S_FINISH;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A failed attempt restarts the whole transaction from the token.
        if (retry_evt) begin
            retry_d = retry_q + 1'b1;
            if (retry_q == RETRY_LAST) begin
                success_d = 1'b0;
                state_d   = S_FINISH;
            end else begin
                enc_pkt_d = tok_pkt(is_in_q ? PID_IN : PID_OUT, addr_q, endp_q);
                state_d   = S_SEND_TOK;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q   <= S_IDLE;
            is_in_q   <= 1'b0;
            addr_q    <= '0;
            endp_q    <= '0;
            wr_data_q <= '0;
            retry_q   <= '0;
            tmo_q     <= '0;
            tx_low_q  <= 1'b0;
            success_q <= 1'b0;
            rd_data_q <= '0;
            enc_pkt_q <= '0;
        end else begin
            state_q   <= state_d;
            is_in_q   <= is_in_d;
            addr_q    <= addr_d;
            endp_q    <= endp_d;
            wr_data_q <= wr_data_d;
            retry_q   <= retry_d;
            tmo_q     <= tmo_d;
            tx_low_q  <= tx_low_d;
            success_q <= success_d;
            rd_data_q <= rd_data_d;
            enc_pkt_q <= enc_pkt_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_FINISH);
    assign success   = success_q;
    assign rd_data   = rd_data_q;
    assign enc_pkt   = enc_pkt_q;
    assign enc_avail = (state_q == S_SEND_TOK) || (state_q == S_SEND_DATA) ||
                       (state_q == S_SEND_ACK);

endmodule

// File: tb/tb_usb_txn_sequencer.sv
// Randomized bench for usb_txn_sequencer: an encoder/decoder model around the DUT and a
// transaction-level reference that predicts the packet stream, outcome and read data.
module tb_usb_txn_sequencer;
    localparam logic [3:0] P_OUT = 4'b1000, P_IN = 4'b1001, P_D0 = 4'b1100;
    localparam logic [3:0] P_D1 = 4'b1101, P_ACK = 4'b0100, P_NAK = 4'b0101;
    localparam int R_TMO = 0, R_GOOD = 1, R_NAK = 2, R_BAD = 3, R_OTHER = 4;

    logic        clk;
    logic        rst_b;
    logic        start;
    logic        is_in;
    logic [6:0]  addr;
    logic [3:0]  endp;
    logic [63:0] wr_data;
    logic        busy;
    logic        done;
    logic        success;
    logic [63:0] rd_data;
    logic [98:0] enc_pkt;
    logic        enc_avail;
    logic        enc_ready;
    logic        rx_valid;
    logic [3:0]  rx_pid;
    logic        rx_crc_ok;
    logic [63:0] rx_data;

    usb_txn_sequencer dut (
        .clk(clk), .rst_b(rst_b), .start(start), .is_in(is_in), .addr(addr), .endp(endp),
        .wr_data(wr_data), .busy(busy), .done(done), .success(success), .rd_data(rd_data),
        .enc_pkt(enc_pkt), .enc_avail(enc_avail), .enc_ready(enc_ready), .rx_valid(rx_valid),
        .rx_pid(rx_pid), .rx_crc_ok(rx_crc_ok), .rx_data(rx_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    logic [98:0] pkts[$];
    int          cap_cyc[$];
    int          txd_cyc[$];
    int          tx_done_cnt = 0;
    int          done_cnt = 0;
    logic        done_success = 1'b0;
    int          txn_dones;

    int          resp_a[8];
    int          dly_a[8];
    logic [63:0] rxd_a[8];
    logic [3:0]  dpid_a[8];
    logic [98:0] exp_pkts[$];
    logic        exp_success;
    logic [63:0] rd_model = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_cnt     <= done_cnt + 1;
            done_success <= success;
        end
    end

    // Encoder model: accepts a word, then holds ready low for 1-3 cycles of "transmission".
    initial begin
        enc_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (enc_avail === 1'b1 && enc_ready) begin
                pkts.push_back(enc_pkt);
                cap_cyc.push_back(cyc);
                @(negedge clk);
                enc_ready = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
                enc_ready = 1'b1;
                tx_done_cnt++;
                txd_cyc.push_back(cyc);
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time expired, required finish before limit");
        $fatal(1);
    end

    function automatic logic [98:0] ref_pkt(input logic [3:0] pid, input int kind,
                                            input logic [6:0] a, input logic [3:0] e,
                                            input logic [63:0] d);
        logic [98:0] p;
        p = '0;
        p[98:91] = 8'b00000001;
        p[90:87] = pid;
        p[86:83] = ~pid;
        if (kind == 1) begin
            for (int i = 0; i < 7; i++) p[82-i] = a[i];
            for (int i = 0; i < 4; i++) p[75-i] = e[i];
        end else if (kind == 2) begin
            for (int i = 0; i < 64; i++) p[82-i] = d[i];
        end
        return p;
    endfunction

    task automatic set_all(input int kind);
        for (int k = 0; k < 8; k++) begin
            resp_a[k] = kind;
            dly_a[k]  = $urandom_range(1, 30);
            rxd_a[k]  = {$urandom, $urandom};
            dpid_a[k] = ($urandom_range(0, 1) == 1) ? P_D1 : P_D0;
        end
    endtask

    task automatic model_txn(input logic in_t, input logic [6:0] a, input logic [3:0] e,
                             input logic [63:0] wd);
        exp_pkts.delete();
        exp_success = 1'b0;
        for (int k = 0; k < 8; k++) begin
            exp_pkts.push_back(ref_pkt(in_t ? P_IN : P_OUT, 1, a, e, '0));
            if (!in_t) exp_pkts.push_back(ref_pkt(P_D0, 2, '0, '0, wd));
            if (resp_a[k] == R_GOOD) begin
                if (in_t) begin
                    exp_pkts.push_back(ref_pkt(P_ACK, 0, '0, '0, '0));
                    rd_model = rxd_a[k];
                end
                exp_success = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_tx(input int target, output bit ok);
        for (int i = 0; i < 3000 && tx_done_cnt < target; i++) @(posedge clk);
        ok = (tx_done_cnt >= target);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL tx_wait: completed packets=%0d required=%0d", tx_done_cnt, target);
        end
    endtask

    task automatic drive_rx(input logic in_t, input int k);
        case (resp_a[k])
            R_GOOD:  begin rx_pid = in_t ? dpid_a[k] : P_ACK; rx_crc_ok = 1'b1; end
            R_NAK:   begin rx_pid = P_NAK;                    rx_crc_ok = 1'b1; end
            R_BAD:   begin rx_pid = in_t ? P_D0 : P_ACK;      rx_crc_ok = 1'b0; end
            default: begin rx_pid = in_t ? P_ACK : P_D1;      rx_crc_ok = 1'b1; end
        endcase
        rx_data  = rxd_a[k];
        rx_valid = 1'b1;
        start    = 1'b0;
        @(negedge clk);
        rx_valid  = 1'b0;
        rx_crc_ok = 1'b0;
        rx_pid    = 4'($urandom);
        rx_data   = {$urandom, $urandom};
    endtask

    // Runs one transaction, answering each attempt as scripted in resp_a/dly_a.
    task automatic run_txn(input logic in_t, input logic [6:0] a, input logic [3:0] e,
                           input logic [63:0] wd, input bit poke);
        int target;
        int d0;
        bit ok;
        for (int i = 0; i < 20 && !enc_ready; i++) @(negedge clk);
        @(negedge clk);
        pkts.delete();
        cap_cyc.delete();
        txd_cyc.delete();
        target = tx_done_cnt;
        d0     = done_cnt;
        start = 1'b1; is_in = in_t; addr = a; endp = e; wr_data = wd;
        @(negedge clk);
        start = 1'b0; is_in = 1'($urandom); addr = 7'($urandom); endp = 4'($urandom);
        wr_data = {$urandom, $urandom};
        for (int k = 0; k < 8; k++) begin
            target += in_t ? 1 : 2;
            wait_tx(target, ok);
            if (!ok) return;
            if (resp_a[k] != R_TMO) begin
                for (int j = 0; j < dly_a[k]; j++) begin
                    @(negedge clk);
                    if (poke && k == 0 && j == 0) begin
                        start = 1'b1; is_in = ~in_t; addr = ~a; endp = ~e;
                    end else begin
                        start = 1'b0;
                    end
                end
                drive_rx(in_t, k);
            end
            if (resp_a[k] == R_GOOD) begin
                if (in_t) begin
                    target += 1;
                    wait_tx(target, ok);
                    if (!ok) return;
                end
                break;
            end
        end
        for (int i = 0; i < 600 && done_cnt == d0; i++) @(negedge clk);
        checks++;
        if (done_cnt == d0) begin
            errors++;
            $display("FAIL done_wait: done pulses=0 required=1 within 600 cycles");
        end
        repeat (4) @(negedge clk);
        txn_dones = done_cnt - d0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks += 6;
        if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
        if (done !== 1'b0)      begin errors++; $display("FAIL reset_done: got %b required 0", done); end
        if (success !== 1'b0)   begin errors++; $display("FAIL reset_success: got %b required 0", success); end
        if (enc_avail !== 1'b0) begin errors++; $display("FAIL reset_avail: got %b required 0", enc_avail); end
        if (enc_pkt !== '0)     begin errors++; $display("FAIL reset_pkt: got %h required 0", enc_pkt); end
        if (rd_data !== '0)     begin errors++; $display("FAIL reset_rd: got %h required 0", rd_data); end
        rst_b = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_out_basic();
        set_all(R_GOOD);
        dly_a[0] = 5;
        model_txn(1'b0, 7'h05, 4'h1, 64'h1);
        run_txn(1'b0, 7'h05, 4'h1, 64'h1, 1'b0);
        checks++;
        if (pkts.size() != 2) begin
            errors++; $display("FAIL out_basic_count: got %0d packets required 2", pkts.size());
        end else begin
            checks += 5;
            if (pkts[0][90:83] !== 8'b10000111) begin errors++; $display("FAIL out_basic_pid: got %b required 10000111", pkts[0][90:83]); end
            if (pkts[0][82:76] !== 7'b1010000)  begin errors++; $display("FAIL out_basic_addr: got %b required 1010000", pkts[0][82:76]); end
            if (pkts[1][82] !== 1'b1)           begin errors++; $display("FAIL out_basic_d0: got %b required 1", pkts[1][82]); end
            if (pkts[1][81:19] !== '0)          begin errors++; $display("FAIL out_basic_drest: got %h required 0", pkts[1][81:19]); end
            if (pkts[1] !== exp_pkts[1])        begin errors++; $display("FAIL out_basic_data: got %h required %h", pkts[1], exp_pkts[1]); end
        end
        checks += 2;
        if (done_success !== 1'b1) begin errors++; $display("FAIL out_basic_success: got %b required 1", done_success); end
        if (txn_dones != 1)        begin errors++; $display("FAIL out_basic_dones: got %0d required 1", txn_dones); end
    endtask

    task automatic test_in_basic();
        set_all(R_GOOD);
        dpid_a[0] = P_D1;
        rxd_a[0]  = 64'hDEADBEEF_01234567;
        model_txn(1'b1, 7'h2A, 4'h3, '0);
        run_txn(1'b1, 7'h2A, 4'h3, '0, 1'b0);
        checks++;
        if (pkts.size() != 2) begin
            errors++; $display("FAIL in_basic_count: got %0d packets required 2", pkts.size());
        end else begin
            checks += 2;
            if (pkts[0] !== exp_pkts[0])        begin errors++; $display("FAIL in_basic_tok: got %h required %h", pkts[0], exp_pkts[0]); end
            if (pkts[1][90:83] !== 8'b01001011) begin errors++; $display("FAIL in_basic_ack: got %b required 01001011", pkts[1][90:83]); end
        end
        checks += 3;
        if (rd_data !== 64'hDEADBEEF_01234567) begin errors++; $display("FAIL in_basic_rd: got %h required deadbeef01234567", rd_data); end
        if (done_success !== 1'b1) begin errors++; $display("FAIL in_basic_success: got %b required 1", done_success); end
        if (success !== 1'b1)      begin errors++; $display("FAIL in_basic_hold: got %b required 1", success); end
    endtask

    // Generic scenario check against the reference model.
    task automatic test_scenario(input string name, input logic in_t, input bit poke,
                                 input bit gap_check);
        logic [6:0]  a;
        logic [3:0]  e;
        logic [63:0] wd;
        a = 7'($urandom); e = 4'($urandom); wd = {$urandom, $urandom};
        model_txn(in_t, a, e, wd);
        run_txn(in_t, a, e, wd, poke);
        checks++;
        if (pkts.size() != exp_pkts.size()) begin
            errors++; $display("FAIL %s_count: got %0d packets required %0d", name, pkts.size(), exp_pkts.size());
        end
        for (int i = 0; i < exp_pkts.size() && i < pkts.size(); i++) begin
            checks++;
            if (pkts[i] !== exp_pkts[i]) begin
                errors++; $display("FAIL %s_pkt%0d: got %h required %h", name, i, pkts[i], exp_pkts[i]);
            end
        end
        checks += 3;
        if (done_success !== exp_success) begin errors++; $display("FAIL %s_success: got %b required %b", name, done_success, exp_success); end
        if (rd_data !== rd_model)         begin errors++; $display("FAIL %s_rd: got %h required %h", name, rd_data, rd_model); end
        if (txn_dones != 1)               begin errors++; $display("FAIL %s_dones: got %0d required 1", name, txn_dones); end
        if (gap_check && cap_cyc.size() >= 8 && txd_cyc.size() >= 7) begin
            for (int k = 0; k < 7; k++) begin
                checks++;
                if (cap_cyc[k+1] - txd_cyc[k] != 257) begin
                    errors++; $display("FAIL %s_gap%0d: got %0d cycles required 257", name, k, cap_cyc[k+1] - txd_cyc[k]);
                end
            end
        end
    endtask

    task automatic test_out_nak();
        set_all(R_NAK);
        resp_a[7] = R_GOOD;
        test_scenario("nak7_ack", 1'b0, 1'b0, 1'b0);
        set_all(R_NAK);
        test_scenario("nak8", 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_in_timeout();
        set_all(R_TMO);
        test_scenario("in_tmo", 1'b1, 1'b0, 1'b1);
    endtask

    task automatic test_in_badcrc();
        set_all(R_BAD);
        test_scenario("in_bad8", 1'b1, 1'b0, 1'b0);
        set_all(R_GOOD);
        resp_a[0] = R_BAD;
        test_scenario("in_bad_good", 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_timeout_race();
        set_all(R_GOOD);
        dly_a[0] = 256;
        test_scenario("hs_race", 1'b0, 1'b0, 1'b0);
        set_all(R_GOOD);
        resp_a[0] = R_NAK;
        dly_a[0]  = 256;
        test_scenario("rx_race_nak", 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_start_busy();
        set_all(R_GOOD);
        resp_a[0] = R_NAK;
        dly_a[0]  = 10;
        test_scenario("busy_start_out", 1'b0, 1'b1, 1'b0);
        set_all(R_GOOD);
        resp_a[0] = R_OTHER;
        dly_a[0]  = 6;
        test_scenario("busy_start_in", 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid();
        int d0;
        int base;
        bit ok;
        for (int i = 0; i < 20 && !enc_ready; i++) @(negedge clk);
        @(negedge clk);
        pkts.delete();
        d0   = done_cnt;
        base = tx_done_cnt;
        start = 1'b1; is_in = 1'b0; addr = 7'h11; endp = 4'h2; wr_data = {$urandom, $urandom};
        @(negedge clk);
        start = 1'b0;
        wait_tx(base + 1, ok);
        for (int i = 0; i < 200 && pkts.size() < 2; i++) @(posedge clk);
        @(negedge clk);
        rst_b = 1'b0;
        #1;
        checks += 4;
        if (busy !== 1'b0)      begin errors++; $display("FAIL midrst_busy: got %b required 0", busy); end
        if (enc_avail !== 1'b0) begin errors++; $display("FAIL midrst_avail: got %b required 0", enc_avail); end
        if (enc_pkt !== '0)     begin errors++; $display("FAIL midrst_pkt: got %h required 0", enc_pkt); end
        if (rd_data !== '0)     begin errors++; $display("FAIL midrst_rd: got %h required 0", rd_data); end
        rd_model = '0;
        @(negedge clk);
        rst_b = 1'b1;
        repeat (20) @(negedge clk);
        checks += 2;
        if (done_cnt != d0) begin errors++; $display("FAIL midrst_done: got %0d pulses required 0", done_cnt - d0); end
        if (busy !== 1'b0)  begin errors++; $display("FAIL midrst_idle: got busy=%b required 0", busy); end
        set_all(R_GOOD);
        test_scenario("after_rst", 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        int r;
        logic in_t;
        for (int t = 0; t < 12; t++) begin
            set_all(R_GOOD);
            for (int k = 0; k < 8; k++) begin
                r = $urandom_range(0, 9);
                resp_a[k] = (r < 1) ? R_TMO : (r < 4) ? R_GOOD : (r < 6) ? R_NAK :
                            (r < 8) ? R_BAD : R_OTHER;
                if ($urandom_range(0, 15) == 0) dly_a[k] = 256;
            end
            in_t = 1'($urandom);
            test_scenario("random", in_t, 1'($urandom), 1'b0);
        end
    endtask

    initial begin
        rst_b = 1'b0; start = 1'b0; is_in = 1'b0; addr = '0; endp = '0; wr_data = '0;
        rx_valid = 1'b0; rx_pid = '0; rx_crc_ok = 1'b0; rx_data = '0;
        test_reset();
        test_out_basic();
        test_in_basic();
        test_out_nak();
        test_in_timeout();
        test_in_badcrc();
        test_timeout_race();
        test_start_busy();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
